fifo_sync: RTL and testbench
============================

# fifo_sync

Single-clock FIFO wrapping the team's dual-port RAM as storage, with valid/ready handshakes on both sides and first-word-fall-through (FWFT) read data. It sits directly upstream of consumers and downstream of producers in the fifo tree. It owns the pointers, occupancy, status flags and the visibility delay caused by the RAM's registered read port.

## Interface
- ADDR_BITS, 8, RAM address width; DEPTH = 2**ADDR_BITS words
- WORD_LENGTH, 8, data width in bits
- AF_THRESH, 2**ADDR_BITS - 2, almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- wr_valid  in  1  producer offers wr_data
- wr_ready  out  1  FIFO can accept; = !full
- wr_data  in  WORD_LENGTH  write word
- rd_valid  out  1  rd_data holds the head word
- rd_ready  in  1  consumer takes head word
- rd_data  out  WORD_LENGTH  head word (FWFT)
- count  out  ADDR_BITS+1  stored words, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH

## Operation
- Push = wr_valid & wr_ready at an edge; pop = rd_valid & rd_ready at an edge. No other writes or reads are accepted, so overflow and underflow cannot occur.
- Write and read pointers are ADDR_BITS+1 bits wide, and the low ADDR_BITS bits address the RAM.
  - Pointers wrap modulo 2*DEPTH.
  - count = wr_ptr - rd_ptr, computed modulo 2*DEPTH.
- RAM write port: write_en = push, w_addr = wr_ptr[ADDR_BITS-1:0].
- RAM read port:
  - r_addr = low bits of (pop ? rd_ptr+1 : rd_ptr), so RAM data_out always tracks the current head.
  - rd_data = RAM data_out, with no extra register.
- Visibility rule: a word pushed at edge N becomes readable (rd_valid=1, correct rd_data) only after edge N+1.
  - One-bit "fresh" tracking is needed, because a RAM write and a read of the same address at edge N return the old contents.
  - rd_valid = (count > 0) and the head word was not written at the immediately preceding edge.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When count==1, the popped word leaves and the new word obeys the visibility rule.
- Push while full: impossible (wr_ready=0). The write port also accepts a push in the same cycle as a pop when full==0 only; full does not look ahead to a pop.
- flush=1 at an edge:
  - wr_ptr = rd_ptr = 0, all outputs return to their reset values on the next cycle.
  - flush overrides a concurrent push and pop; the pushed word is dropped.
- almost_full and full derive combinationally from count.

## Timing
- Reset (rst_n=0, asynchronous) values:
  - count=0, empty=1, full=0, almost_full=0 (AF_THRESH>0).
  - rd_valid=0, wr_ready=1.
  - Pointers and the fresh flag are 0.
- Reset mid-operation drops rd_valid immediately, not at the next edge. RAM contents are left unchanged and are never visible.
- Latency from a push at edge N to rd_valid=1 is one further edge (after edge N+1). Throughput is one push and one pop per cycle.
- count, full, empty and almost_full update after the edge where the push or pop occurs.
- Back-to-back pops at one word per cycle require no bubbles once the head is visible.
- rd_data must not change while rd_valid=1 and rd_ready=0.
- wr_ready does not depend on rd_ready, so there is no combinational path from the read side to the write side.

## Structure
- Storage: one instance of RAM_DUALPORT with r_clk = w_clk = clk. This is the only sub-module.
- Shared fifo package: DEPTH, pointer width (ADDR_BITS+1) and count width derived from ADDR_BITS, plus the AF_THRESH default.
- Control logic (pointers, fresh flag, flags) lives in this module, about 150–200 lines.

## Test plan
- Reset then idle:
  - count=0, empty=1, rd_valid=0, wr_ready=1.
  - Assert rst_n=0 mid-burst → rd_valid falls before the next edge.
- Single word: push 0xA5 at edge N → rd_valid=0 after N, rd_valid=1 and rd_data=0xA5 after N+1; pop → empty=1, count=0.
- Fill (ADDR_BITS=3):
  - Push 8 words 0..7 → full=1, wr_ready=0, almost_full from count=6.
  - A 9th wr_valid is ignored.
  - Drain → reads 0..7 in order across the pointer wrap.
- Simultaneous push and pop:
  - At count=1 with head 0x11, push 0x22 and pop in the same cycle → count stays 1, rd_valid=0 for one cycle, then rd_data=0x22.
  - Sustained streaming at count=3 keeps count at 3.
- Backpressure: hold rd_ready=0 for 5 cycles with rd_valid=1 → rd_data is stable and count grows with pushes.
- Flush with concurrent push and pop at count=4 → next cycle count=0, empty=1, rd_valid=0; the subsequent push 0x5C is read back as 0x5C.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared sizing helpers and status types for the fifo tree.
// Everything is derived from ADDR_BITS so all FIFOs agree on pointer/count widths.
package fifo_sync_pkg;

  localparam int FIFO_ADDR_BITS   = 8;
  localparam int FIFO_WORD_LENGTH = 8;

  function automatic int fifo_depth(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  // One extra bit separates full from empty when the low bits match.
  function automatic int fifo_ptr_w(input int addr_bits);
    return addr_bits + 1;
  endfunction

  function automatic int fifo_af_default(input int addr_bits);
    return (1 << addr_bits) - 2;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM with a registered read port.
// A read and a write to the same address on one edge return the old word.
module RAM_DUALPORT #(
  parameter int ADDR_BITS   = 8,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   w_clk,
  input  logic                   write_en,
  input  logic [ADDR_BITS-1:0]   w_addr,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   r_clk,
  input  logic [ADDR_BITS-1:0]   r_addr,
  output logic [WORD_LENGTH-1:0] data_out
);

  logic [WORD_LENGTH-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge w_clk) begin
    if (write_en) mem[w_addr] <= data_in;
  end

  always_ff @(posedge r_clk) begin
    data_out <= mem[r_addr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FWFT FIFO over RAM_DUALPORT with valid/ready on both sides.
// Owns pointers, occupancy, status flags and the one-edge visibility delay of new heads.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int ADDR_BITS   = FIFO_ADDR_BITS,
  parameter int WORD_LENGTH = FIFO_WORD_LENGTH,
  parameter int AF_THRESH   = fifo_af_default(ADDR_BITS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WORD_LENGTH-1:0] wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WORD_LENGTH-1:0] rd_data,
  output logic [ADDR_BITS:0]     count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full
);

  localparam int PTR_W = fifo_ptr_w(ADDR_BITS);
  localparam int DEPTH = fifo_depth(ADDR_BITS);

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_THRESH);
  localparam ptr_t ONE_P   = ptr_t'(1);

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        rd_ptr_adv;
  ptr_t        occ;
  logic        fresh_q, fresh_d;
  logic        push, pop;
  fifo_flags_t flags;

  logic [ADDR_BITS-1:0] ram_w_addr;
  logic [ADDR_BITS-1:0] ram_r_addr;

  // Occupancy and flags come straight from the pointer difference (mod 2*DEPTH).
  assign occ               = wr_ptr_q - rd_ptr_q;
  assign flags.full        = (occ == DEPTH_P);
  assign flags.empty       = (occ == '0);
  assign flags.almost_full = (occ >= AF_P);

  assign count       = occ;
  assign full        = flags.full;
  assign empty       = flags.empty;
  assign almost_full = flags.almost_full;

  // wr_ready looks only at stored state, never at rd_ready.
  assign wr_ready = !flags.full;
  assign rd_valid = !flags.empty && !fresh_q;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  assign rd_ptr_adv = pop ? (rd_ptr_q + ONE_P) : rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_adv;
    fresh_d  = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + ONE_P;
    // The slot written this edge becomes the head: the RAM read of it returns stale data.
    fresh_d = push && (wr_ptr_q == rd_ptr_adv);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fresh_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fresh_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fresh_q  <= fresh_d;
    end
  end

  // Read address follows the next head so data_out always presents the current head.
  assign ram_w_addr = wr_ptr_q[ADDR_BITS-1:0];
  assign ram_r_addr = rd_ptr_adv[ADDR_BITS-1:0];

  RAM_DUALPORT #(
    .ADDR_BITS   (ADDR_BITS),
    .WORD_LENGTH (WORD_LENGTH)
  ) u_ram (
    .w_clk    (clk),
    .write_en (push),
    .w_addr   (ram_w_addr),
    .data_in  (wr_data),
    .r_clk    (clk),
    .r_addr   (ram_r_addr),
    .data_out (rd_data)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync (ADDR_BITS=3): driver queues expected words, monitor checks pops.
module tb_fifo_sync;

  localparam int AB = 3;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic [WL-1:0] wr_data = '0;
  logic          wr_ready, rd_valid, full, empty, almost_full;
  logic [WL-1:0] rd_data;
  logic [AB:0]   count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WL-1:0] exp_q[$];

  fifo_sync #(.ADDR_BITS(AB), .WORD_LENGTH(WL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [WL-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    exp_q.push_back(d);
  endtask

  // Monitor: a pop will happen at the coming edge, so the head must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && !flush && rd_valid && rd_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no word", rd_data);
      end else begin
        logic [WL-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    // Reset and idle
    repeat (2) tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    tick();
    chk("idle_empty", empty, 1);

    // Single word visibility
    put(8'hA5);
    tick();
    wr_valid = 1'b0;
    chk("single_hidden", rd_valid, 0);
    chk("single_count", count, 1);
    chk("single_not_empty", empty, 0);
    tick();
    chk("single_visible", rd_valid, 1);
    chk("single_data", rd_data, 8'hA5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("single_empty", empty, 1);
    chk("single_count0", count, 0);

    // Fill across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      put(WL'(i));
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
    end
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_count8", count, 8);
    rd_ready = 1'b1;
    repeat (8) tick();
    rd_ready = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    chk("drain_sb_left", exp_q.size(), 0);

    // Simultaneous push/pop at count=1
    put(8'h11);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("pp_head", rd_data, 8'h11);
    put(8'h22);
    rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("pp_count", count, 1);
    chk("pp_hidden", rd_valid, 0);
    tick();
    chk("pp_visible", rd_valid, 1);
    chk("pp_data", rd_data, 8'h22);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pp_empty", empty, 1);

    // Streaming at count=3
    put(8'h30); tick();
    put(8'h31); tick();
    put(8'h32); tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put(WL'(8'h40 + i));
      tick();
      chk("stream_count", count, 3);
    end
    wr_valid = 1'b0;
    repeat (3) tick();
    rd_ready = 1'b0;
    chk("stream_drained", count, 0);

    // Backpressure: head stays put while pushes continue
    put(8'h50); tick();
    put(8'h51); tick();
    for (int i = 0; i < 5; i++) begin
      put(WL'(8'h60 + i));
      tick();
      chk("bp_valid", rd_valid, 1);
      chk("bp_data", rd_data, 8'h50);
      chk("bp_count", count, 3 + i);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (7) tick();
    rd_ready = 1'b0;
    chk("bp_drained", count, 0);

    // Flush with concurrent push and pop at count=4
    for (int i = 0; i < 4; i++) begin
      put(WL'(8'h70 + i));
      tick();
    end
    wr_valid = 1'b0;
    tick();
    chk("fl_count4", count, 4);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h74;
    rd_ready = 1'b1;
    tick();
    exp_q.delete();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_rd_valid", rd_valid, 0);
    put(8'h5C);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("fl_post_valid", rd_valid, 1);
    chk("fl_post_data", rd_data, 8'h5C);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("fl_post_empty", empty, 1);

    // Asynchronous reset mid-burst
    put(8'h80); tick();
    put(8'h81); tick();
    put(8'h82); tick();
    wr_valid = 1'b0;
    chk("ar_pre_valid", rd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rd_valid", rd_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_wr_ready", wr_ready, 1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
